// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// Shared types for the packet round-robin arbiter.
package axis_arb_pkg;

  // Arbiter FSM: IDLE arbitrates (one bubble per packet), BUSY streams one packet.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axis_pkt_rr_arbiter_if.sv
// Bundle of the N_SRC source streams, the merged output stream and the FSM debug tap.
//
// Handshake: a beat transfers on a rising aclk edge where tvalid and tready are
// both 1. A producer may raise tvalid without waiting for tready, and once tvalid
// is 1 it holds tdata/tlast stable until the beat transfers. Each s_axis_* bit or
// slice belongs to one source; m_axis_* is the single merged stream.
interface axis_pkt_rr_arbiter_if #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 8
);
  import axis_arb_pkg::*;

  localparam int ID_WIDTH = $clog2(N_SRC);

  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [N_SRC-1:0]            s_axis_tvalid;
  logic [N_SRC-1:0]            s_axis_tlast;
  logic [N_SRC-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tlast;
  logic [ID_WIDTH-1:0]         m_axis_tid;
  logic                        m_axis_tready;
  arb_state_t                  dbg_state;

  // Arbiter side: consumes the sources, produces the merged stream.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output dbg_state
  );

  // Environment side: drives the sources and the downstream ready.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  dbg_state
  );

endinterface

// File: rtl/axis_pkt_rr_arbiter_pick.sv
// Combinational round-robin picker: first requester strictly after i_last, wrapping.
// Rotate the request vector so the search starts at i_last+1, priority-encode the
// lowest set bit, then add the rotation back to get an absolute index.
module axis_rr_pick #(
  parameter int N_SRC = 4,
  localparam int IW   = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_gnt_idx,
  output logic             o_any_req
);

  logic [IW-1:0]        w_start;
  logic [2*N_SRC-2:0]   w_req2;
  logic [N_SRC-1:0]     w_rot;
  logic [IW-1:0]        w_off;
  logic [IW:0]          w_sum;

  // Rotate, priority encode, un-rotate.
  always_comb begin
    w_start = (i_last == IW'(N_SRC - 1)) ? '0 : i_last + IW'(1);
    w_req2  = {i_req[N_SRC-2:0], i_req};
    w_rot   = w_req2[{1'b0, w_start} +: N_SRC];
    w_off   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (IW + 1)'(N_SRC)) w_sum = w_sum - (IW + 1)'(N_SRC);
    o_gnt_idx = w_sum[IW-1:0];
    o_any_req = |i_req;
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: N_SRC AXI-Stream sources share one registered
// output. A grant is held from a packet's first beat to its tlast, and the owning
// source index travels with every beat on m_axis_tid.
module axis_pkt_rr_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_pkt_rr_arbiter_if.slave  bus
);
  import axis_arb_pkg::*;

  localparam int ID_WIDTH = $clog2(N_SRC);

  arb_state_t            r_state;
  logic [ID_WIDTH-1:0]   r_grant;
  logic [ID_WIDTH-1:0]   r_last_grant;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [ID_WIDTH-1:0]   r_tid;

  logic [ID_WIDTH-1:0]   w_pick_idx;
  logic                  w_any_req;
  logic                  w_slot_free;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_load;
  logic [N_SRC-1:0]      w_s_tready;

  axis_rr_pick #(.N_SRC(N_SRC)) u_pick (
    .i_req     (bus.s_axis_tvalid),
    .i_last    (r_last_grant),
    .o_gnt_idx (w_pick_idx),
    .o_any_req (w_any_req)
  );

  // The output slot can take a beat when empty or being drained this cycle.
  assign w_slot_free = ~r_tvalid | bus.m_axis_tready;
  assign w_sel_valid = bus.s_axis_tvalid[r_grant];
  assign w_sel_last  = bus.s_axis_tlast[r_grant];
  assign w_sel_data  = bus.s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_load      = (r_state == ARB_BUSY) & w_sel_valid & w_slot_free;

  // Only the granted source sees ready, and only while streaming.
  always_comb begin
    w_s_tready = '0;
    if (r_state == ARB_BUSY) w_s_tready[r_grant] = w_slot_free;
  end

  // Arbitration FSM: pick in IDLE, hold the grant until the packet's tlast is accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_grant <= ID_WIDTH'(N_SRC - 1);
    end else if (r_state == ARB_IDLE) begin
      if (w_any_req) begin
        r_grant <= w_pick_idx;
        r_state <= ARB_BUSY;
      end
    end else if (w_load && w_sel_last) begin
      r_last_grant <= r_grant;
      r_state      <= ARB_IDLE;
    end
  end

  // Output register: a new beat replaces a draining one, otherwise a drain empties it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tid    <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_sel_last;
      r_tdata  <= w_sel_data;
      r_tid    <= r_grant;
    end else if (bus.m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign bus.s_axis_tready = w_s_tready;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.m_axis_tlast  = r_tlast;
  assign bus.m_axis_tid    = r_tid;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Bench for axis_pkt_rr_arbiter: per-cycle directed vector table, a hand-written
// async-reset sequence, and a random phase with an expected-beat queue.
module tb_axis_pkt_rr_arbiter;
  import axis_arb_pkg::*;

  localparam int N_SRC = 4;
  localparam int DW    = 8;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_pkt_rr_arbiter_if #(.N_SRC(N_SRC), .DATA_WIDTH(DW)) bus ();

  axis_pkt_rr_arbiter #(.N_SRC(N_SRC), .DATA_WIDTH(DW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] vld, input logic [3:0] lst,
                       input logic [31:0] data, input logic mrdy);
    bus.s_axis_tvalid = vld;
    bus.s_axis_tlast  = lst;
    bus.s_axis_tdata  = data;
    bus.m_axis_tready = mrdy;
  endtask

  task automatic reset_dut();
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] data;
    logic        mrdy;
    logic [3:0]  e_srdy;
    logic        e_mvld;
    logic [7:0]  e_data;
    logic        e_last;
    logic [1:0]  e_tid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input logic [3:0] vld, input logic [3:0] lst,
                     input logic [31:0] data, input logic mrdy, input logic [3:0] e_srdy,
                     input logic e_mvld, input logic [7:0] e_data, input logic e_last,
                     input logic [1:0] e_tid);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.data = data; v.mrdy = mrdy;
    v.e_srdy = e_srdy; v.e_mvld = e_mvld; v.e_data = e_data; v.e_last = e_last;
    v.e_tid = e_tid;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard (random phase) ----------------
  logic [10:0] exp_q[$];
  logic [3:0]  src_vld;
  logic [3:0]  src_lst;
  logic [7:0]  src_dat[4];
  logic [5:0]  src_seq[4];
  logic [3:0]  acc;
  bit          in_pkt;
  logic [1:0]  pkt_tid;

  // mode 0: random packets and stalls; 1: new beats all end packets; 2: no new beats
  task automatic rand_cycle(input int mode);
    logic [3:0]  srdy;
    logic [10:0] e;
    @(negedge aclk);
    for (int i = 0; i < N_SRC; i++) begin
      if (acc[i]) src_vld[i] = 1'b0;
      if (!src_vld[i] && mode < 2 && $urandom_range(0, 2) != 0) begin
        src_vld[i] = 1'b1;
        src_dat[i] = {2'(i), src_seq[i]};
        src_seq[i] = src_seq[i] + 6'd1;
        src_lst[i] = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
      end
    end
    drive(src_vld, src_lst, {src_dat[3], src_dat[2], src_dat[1], src_dat[0]},
          (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    srdy = bus.s_axis_tready;
    check("rand_srdy_onehot0", 32'($onehot0(srdy)), 32'd1);
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rand_sb_extra_beat: got tid=%0d data=0x%0h expected no beat",
                 bus.m_axis_tid, bus.m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        check("rand_sb_beat", {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata}, e);
      end
      if (in_pkt) check("rand_no_interleave", bus.m_axis_tid, pkt_tid);
      in_pkt  = !bus.m_axis_tlast;
      pkt_tid = bus.m_axis_tid;
    end
    acc = src_vld & srdy;
    for (int i = 0; i < N_SRC; i++) begin
      if (acc[i]) exp_q.push_back({2'(i), src_lst[i], src_dat[i]});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);

    // Reset values straight out of reset.
    reset_dut();
    #1;
    check("rst_mvld",  bus.m_axis_tvalid, 0);
    check("rst_mlast", bus.m_axis_tlast, 0);
    check("rst_mdata", bus.m_axis_tdata, 0);
    check("rst_tid",   bus.m_axis_tid, 0);
    check("rst_srdy",  bus.s_axis_tready, 0);
    check("rst_state", bus.dbg_state, ARB_IDLE);
    @(negedge aclk);

    // src0 3-beat packet, downstream always ready.
    add(1, 4'b0001, 4'b0000, 32'h000000A0, 1, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0001, 4'b0000, 32'h000000A0, 1, 4'b0001, 0, 8'h00, 0, 0);
    add(0, 4'b0001, 4'b0000, 32'h000000A1, 1, 4'b0001, 1, 8'hA0, 0, 0);
    add(0, 4'b0001, 4'b0001, 32'h000000A2, 1, 4'b0001, 1, 8'hA1, 0, 0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'hA2, 1, 0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 0);
    // All four sources with 2-beat packets: grants 0,1,2,3,0 with a bubble each.
    add(1, 4'b1111, 4'b0000, 32'h30201000, 1, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 4'b0000, 32'h30201000, 1, 4'b0001, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 4'b0001, 32'h30201001, 1, 4'b0001, 1, 8'h00, 0, 0);
    add(0, 4'b1111, 4'b0000, 32'h30201002, 1, 4'b0000, 1, 8'h01, 1, 0);
    add(0, 4'b1111, 4'b0000, 32'h30201002, 1, 4'b0010, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 4'b0010, 32'h30201102, 1, 4'b0010, 1, 8'h10, 0, 1);
    add(0, 4'b1111, 4'b0000, 32'h30201202, 1, 4'b0000, 1, 8'h11, 1, 1);
    add(0, 4'b1111, 4'b0000, 32'h30201202, 1, 4'b0100, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 4'b0100, 32'h30211202, 1, 4'b0100, 1, 8'h20, 0, 2);
    add(0, 4'b1111, 4'b0000, 32'h30221202, 1, 4'b0000, 1, 8'h21, 1, 2);
    add(0, 4'b1111, 4'b0000, 32'h30221202, 1, 4'b1000, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 4'b1000, 32'h31221202, 1, 4'b1000, 1, 8'h30, 0, 3);
    add(0, 4'b1111, 4'b0000, 32'h32221202, 1, 4'b0000, 1, 8'h31, 1, 3);
    add(0, 4'b1111, 4'b0000, 32'h32221202, 1, 4'b0001, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 4'b0001, 32'h32221203, 1, 4'b0001, 1, 8'h02, 0, 0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'h03, 1, 0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 0);
    // src2 packet with downstream ready 1,0,0,1: output holds C1 while stalled.
    add(1, 4'b0100, 4'b0000, 32'h00C00000, 1, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0100, 4'b0000, 32'h00C00000, 1, 4'b0100, 0, 8'h00, 0, 0);
    add(0, 4'b0100, 4'b0000, 32'h00C10000, 1, 4'b0100, 1, 8'hC0, 0, 2);
    add(0, 4'b0100, 4'b0100, 32'h00C20000, 0, 4'b0000, 1, 8'hC1, 0, 2);
    add(0, 4'b0100, 4'b0100, 32'h00C20000, 0, 4'b0000, 1, 8'hC1, 0, 2);
    add(0, 4'b0100, 4'b0100, 32'h00C20000, 1, 4'b0100, 1, 8'hC1, 0, 2);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'hC2, 1, 2);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 0);
    // Only src1, single-beat packets back to back: one beat every 2 cycles.
    add(1, 4'b0010, 4'b0010, 32'h0000D000, 1, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0010, 4'b0010, 32'h0000D000, 1, 4'b0010, 0, 8'h00, 0, 0);
    add(0, 4'b0010, 4'b0010, 32'h0000D100, 1, 4'b0000, 1, 8'hD0, 1, 1);
    add(0, 4'b0010, 4'b0010, 32'h0000D100, 1, 4'b0010, 0, 8'h00, 0, 0);
    add(0, 4'b0010, 4'b0010, 32'h0000D200, 1, 4'b0000, 1, 8'hD1, 1, 1);
    add(0, 4'b0010, 4'b0010, 32'h0000D200, 1, 4'b0010, 0, 8'h00, 0, 0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'hD2, 1, 1);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 0);
    // Search starts after last grant: src2 served, then src3 beats src1, then src1.
    add(1, 4'b0100, 4'b0100, 32'h00F20000, 1, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0100, 4'b0100, 32'h00F20000, 1, 4'b0100, 0, 8'h00, 0, 0);
    add(0, 4'b1010, 4'b1010, 32'hF300F100, 1, 4'b0000, 1, 8'hF2, 1, 2);
    add(0, 4'b1010, 4'b1010, 32'hF300F100, 1, 4'b1000, 0, 8'h00, 0, 0);
    add(0, 4'b0010, 4'b0010, 32'h0000F100, 1, 4'b0000, 1, 8'hF3, 1, 3);
    add(0, 4'b0010, 4'b0010, 32'h0000F100, 1, 4'b0010, 0, 8'h00, 0, 0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'hF1, 1, 1);

    foreach (vecs[k]) begin
      if (vecs[k].rst) reset_dut();
      drive(vecs[k].vld, vecs[k].lst, vecs[k].data, vecs[k].mrdy);
      #1;
      check($sformatf("v%0d_srdy", k), bus.s_axis_tready, vecs[k].e_srdy);
      check($sformatf("v%0d_mvld", k), bus.m_axis_tvalid, vecs[k].e_mvld);
      if (vecs[k].e_mvld) begin
        check($sformatf("v%0d_mdata", k), bus.m_axis_tdata, vecs[k].e_data);
        check($sformatf("v%0d_mlast", k), bus.m_axis_tlast, vecs[k].e_last);
        check($sformatf("v%0d_tid", k),   bus.m_axis_tid, vecs[k].e_tid);
      end
      @(negedge aclk);
    end

    // Async reset pulse in the middle of a src3 4-beat packet.
    reset_dut();
    drive(4'b1000, 4'b0000, 32'hE0000000, 1'b1);
    @(negedge aclk); #1;
    check("ar_grant3_srdy", bus.s_axis_tready, 4'b1000);
    @(negedge aclk);
    drive(4'b1000, 4'b0000, 32'hE1000000, 1'b1);
    #1;
    check("ar_beat0_mvld", bus.m_axis_tvalid, 1);
    check("ar_beat0_data", bus.m_axis_tdata, 8'hE0);
    check("ar_beat0_tid",  bus.m_axis_tid, 3);
    #1 aresetn = 1'b0;
    #1;
    check("ar_async_mvld",  bus.m_axis_tvalid, 0);
    check("ar_async_srdy",  bus.s_axis_tready, 0);
    check("ar_async_state", bus.dbg_state, ARB_IDLE);
    check("ar_async_mdata", bus.m_axis_tdata, 0);
    drive(4'b1001, 4'b0000, 32'hE10000F0, 1'b1);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk); #1;
    check("ar_regrant_src0", bus.s_axis_tready, 4'b0001);
    check("ar_no_stale_beat", bus.m_axis_tvalid, 0);
    @(negedge aclk);

    // Random traffic with stalls, then drain.
    reset_dut();
    src_vld = '0; src_lst = '0; acc = '0; in_pkt = 1'b0; pkt_tid = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_dat[i] = '0;
      src_seq[i] = '0;
    end
    exp_q.delete();
    for (int c = 0; c < 10000; c++) rand_cycle(0);
    for (int c = 0; c < 40; c++) rand_cycle(1);
    for (int c = 0; c < 40; c++) rand_cycle(2);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_src_pending", src_vld & ~acc, 0);
    check("rand_end_mvld", bus.m_axis_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
